sh4a_fetch: RTL

Instruction fetch front end for the SH4A core: it generates the 16-bit instruction stream that `sh4a_decode` consumes. It reads aligned 32-bit words from instruction memory over a request/acknowledge interface, splits each word into two halfwords (lower address = bits [15:0]), and buffers them in a small FIFO. Each halfword is presented to the decode stage with its PC under a valid/ready handshake. Branch/exception redirects flush the FIFO and restart fetch, and any response already in flight is discarded.

---
 rtl/sh4a_fetch.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/sh4a_fetch.sv
// SH4A instruction fetch front end: fetches aligned 32-bit words, splits them
// into halfwords and hands {insn, pc} pairs to decode through a small FIFO.
module sh4a_fetch #(
    parameter logic [31:0] RESET_PC = 32'hA000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        fetch_valid,
    output logic [15:0] fetch_insn,
    output logic [31:0] fetch_pc,
    input  logic        fetch_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] ISSUE_MAX = CW'(DEPTH - 2);

    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

    state_t        state;
    logic [31:0]   next_pc;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [CW-1:0] push_n;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] tail_p1;
    logic [15:0]   insn_q [DEPTH];
    logic [31:0]   pc_q   [DEPTH];
    logic          pop;
    logic          push_ok;
    logic          issue_ok;
    logic [31:0]   word_addr;
    logic [31:0]   word_next;

    // While a request is outstanding mem_addr is the word being fetched.
    assign word_addr   = mem_addr;
    assign word_next   = word_addr + 32'd4;
    assign push_ok     = (state == WAIT) && mem_ack && !redirect_valid;
    assign push_n      = !push_ok ? '0 : (next_pc[1] ? CW'(1) : CW'(2));
    assign pop         = fetch_valid && fetch_ready && !redirect_valid;
    assign count_next  = count + push_n - CW'(pop);
    assign issue_ok    = count_next <= ISSUE_MAX;
    assign tail_p1     = tail + PW'(1);
    assign fetch_valid = count != '0;
    assign fetch_insn  = insn_q[head];
    assign fetch_pc    = pc_q[head];

    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            if (next_pc[1]) begin
                insn_q[tail]    <= mem_rdata[31:16];
                pc_q[tail]      <= word_addr + 32'd2;
            end else begin
                insn_q[tail]    <= mem_rdata[15:0];
                pc_q[tail]      <= word_addr;
                insn_q[tail_p1] <= mem_rdata[31:16];
                pc_q[tail_p1]   <= word_addr + 32'd2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_addr <= RESET_PC & ~32'd3;
            next_pc  <= RESET_PC;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
        end else if (redirect_valid) begin
            // Flush wins over everything; an in-flight request is still
            // completed on the bus but its data is thrown away.
            count   <= '0;
            head    <= '0;
            tail    <= '0;
            next_pc <= redirect_pc & ~32'd1;
            case (state)
                IDLE: state <= IDLE;
                WAIT: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        state   <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end else begin
            count <= count_next;
            head  <= head + PW'(pop);
            tail  <= tail + push_n[PW-1:0];
            case (state)
                IDLE: begin
                    if (issue_ok) begin
                        mem_req  <= 1'b1;
                        mem_addr <= next_pc & ~32'd3;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        next_pc <= word_next;
                        if (issue_ok) begin
                            mem_addr <= word_next;
                        end else begin
                            mem_req <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                DISCARD: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule
